tsn_desc_fifo_reader: RTL

TSN_DESC_FIFO_READER -- requirements
Module: tsn_desc_fifo_reader

---
 rtl/tsn_desc_fifo_reader_pkg.sv | 30 +++
 rtl/tsn_desc_out_reg.sv | 28 ++
 rtl/tsn_desc_fifo_reader.sv | 116 +++++++++++
 3 files changed

// File: rtl/tsn_desc_fifo_reader_pkg.sv
// Shared definitions for the TSN descriptor FIFO reader: widths, FSM encoding
// and the packet-length field extractor.
package tsn_desc_fifo_reader_pkg;

  localparam int unsigned DESC_DW     = 71;
  localparam int unsigned DESC_LW     = 12;
  localparam int unsigned DESC_MAX_W  = 128;
  localparam int unsigned BUDGET_W    = 16;
  localparam int unsigned DESC_CNT_W  = 32;
  localparam int unsigned STALL_CNT_W = 16;
  localparam int unsigned ST_W        = 2;

  localparam logic [ST_W-1:0] ST_CLOSED  = 2'd0;
  localparam logic [ST_W-1:0] ST_OPEN    = 2'd1;
  localparam logic [ST_W-1:0] ST_BLOCKED = 2'd2;

  typedef logic [BUDGET_W-1:0] budget_t;

  // Length field sits in the top lw bits of a dw-wide descriptor; zero-extended.
  function automatic budget_t len_field(input logic [DESC_MAX_W-1:0] desc,
                                        input int unsigned dw,
                                        input int unsigned lw);
    logic [DESC_MAX_W-1:0] shifted;
    logic [DESC_MAX_W-1:0] mask;
    shifted = desc >> (dw - lw);
    mask    = (DESC_MAX_W'(1) << lw) - DESC_MAX_W'(1);
    return budget_t'(shifted & mask);
  endfunction

endpackage

// File: rtl/tsn_desc_out_reg.sv
// Single-stage valid/ready output register: loads on demand, holds until accepted.
module tsn_desc_out_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         ready,
  output logic [W-1:0] q,
  output logic         valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      valid <= 1'b0;
    end else begin
      if (load) begin
        q     <= d;
        valid <= 1'b1;
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tsn_desc_fifo_reader.sv
// Pops descriptors from a show-ahead FIFO while the transmission gate is open,
// spending a per-window byte budget; a head that does not fit blocks the window.
module tsn_desc_fifo_reader
  import tsn_desc_fifo_reader_pkg::*;
#(
  parameter int unsigned DW = DESC_DW,
  parameter int unsigned LW = DESC_LW
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [DW-1:0]          iv_fifo_q,
  input  logic                   i_fifo_empty,
  output logic                   o_fifo_rdreq,
  input  logic                   i_gate_open,
  input  logic [BUDGET_W-1:0]    iv_window_bytes,
  output logic [DW-1:0]          ov_desc,
  output logic                   o_desc_valid,
  input  logic                   i_desc_ready,
  output logic                   o_guard_stall,
  output logic [DESC_CNT_W-1:0]  ov_desc_cnt,
  output logic [STALL_CNT_W-1:0] ov_stall_cnt
);

  logic [ST_W-1:0] state, state_nxt;
  budget_t         remaining, remaining_nxt;
  budget_t         head_len;
  logic            gate_open_d;
  logic            out_free;
  logic            fits;
  logic            pop;

  assign head_len = len_field(DESC_MAX_W'(iv_fifo_q), DW, LW);
  assign out_free = !o_desc_valid || i_desc_ready;
  assign fits     = head_len <= remaining;

  // Gate-low cycles never pop, even before the FSM has left OPEN.
  assign pop          = (state == ST_OPEN) && i_gate_open && !i_fifo_empty && fits && out_free;
  assign o_fifo_rdreq = pop;

  // State and budget registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_CLOSED;
      remaining     <= '0;
      gate_open_d   <= 1'b0;
      o_guard_stall <= 1'b0;
    end else begin
      state         <= state_nxt;
      remaining     <= remaining_nxt;
      gate_open_d   <= i_gate_open;
      o_guard_stall <= (state_nxt == ST_BLOCKED);
    end
  end

  // Next-state and budget update
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    case (state)
      ST_CLOSED: begin
        if (i_gate_open && !gate_open_d) begin
          state_nxt     = ST_OPEN;
          remaining_nxt = iv_window_bytes;
        end
      end
      ST_OPEN: begin
        if (!i_gate_open) begin
          state_nxt     = ST_CLOSED;
          remaining_nxt = '0;
        end else if (pop) begin
          remaining_nxt = remaining - head_len;
        end else if (!i_fifo_empty && !fits) begin
          state_nxt = ST_BLOCKED;
        end
      end
      ST_BLOCKED: begin
        if (!i_gate_open) begin
          state_nxt     = ST_CLOSED;
          remaining_nxt = '0;
        end
      end
      default: begin
        state_nxt     = ST_CLOSED;
        remaining_nxt = '0;
      end
    endcase
  end

  // Forwarded-descriptor and guard-stall statistics
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ov_desc_cnt  <= '0;
      ov_stall_cnt <= '0;
    end else begin
      if (pop) begin
        ov_desc_cnt <= ov_desc_cnt + DESC_CNT_W'(1);
      end
      if (o_guard_stall && (ov_stall_cnt != '1)) begin
        ov_stall_cnt <= ov_stall_cnt + STALL_CNT_W'(1);
      end
    end
  end

  tsn_desc_out_reg #(
    .W (DW)
  ) u_out_reg (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .load  (pop),
    .d     (iv_fifo_q),
    .ready (i_desc_ready),
    .q     (ov_desc),
    .valid (o_desc_valid)
  );

endmodule
